g15_key_sync: RTL and testbench
===============================

Name: g15_key_sync

Overview:
- Parametrised N-channel synchroniser, debouncer and press-event queue for typewriter function keys and switch contacts, e.g. <A>..<T>, <Ⓢ>, <F-B>, GO/NO_GO/BP/PUNCH/REWIND/SA.
- Sits between the raw PL1 key pins and io_top.
- Generalises the fixed one-wire-per-key hookup: any channel count, configurable filter length, level outputs plus a one-at-a-time valid/ack press stream with overrun detection.

Parameters:
- NUM_KEYS, 13, number of key/contact channels (1..32)
- SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2)
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required to accept a level change (>=1)
- CODE_W, $clog2(NUM_KEYS) (min 1), width of key_code

Ports:
- CLOCK  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_raw  in  NUM_KEYS  raw asynchronous contact inputs, 1 = closed
- enable  in  1  typewriter ENABLE switch; 0 suppresses press capture
- key_level  out  NUM_KEYS  debounced contact state
- key_press  out  NUM_KEYS  one-cycle pulse on debounced 0->1
- key_valid  out  1  a press event is presented
- key_code  out  CODE_W  channel index of the presented event
- key_ack  in  1  consumer accepts the presented event
- key_overrun  out  1  sticky: a press was lost
- overrun_clr  in  1  clears key_overrun

Behaviour:
- Reset (async assert, sync-released by the user): synchronisers, key_level, key_press, pending, key_valid, key_code and key_overrun all 0; debounce counters 0.
- Per channel: SYNC_STAGES-deep synchroniser feeding a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Counter increments each cycle synced != key_level.
  - Counter resets to 0 on any cycle synced == key_level.
  - When synced != key_level and counter == DEBOUNCE_CYCLES-1: key_level toggles and counter clears.
  - Latency from a clean pin edge to key_level: SYNC_STAGES+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never reaches key_level.
- key_press[i] = key_level rising for channel i. It is registered, coincident with the key_level rise, and independent of enable.
- pending[NUM_KEYS] bit-vector:
  - A key_press with enable=1 sets pending[i].
  - If pending[i] is already 1 and is not being consumed that cycle, key_overrun sets instead and the press is dropped.
- Presenter FSM:
  - IDLE: if any pending bit is set, load key_code = lowest set index, clear that pending bit, go to PRESENT (key_valid=1 next cycle).
  - PRESENT: key_valid and key_code held stable. On key_ack=1, go to IDLE and key_valid=0 next cycle. At most one event every 2 cycles.
  - key_ack in IDLE is ignored.
- Simultaneous events:
  - pending set and clear on the same channel in the same cycle: the set wins; the bit stays 1 and there is no overrun.
  - overrun set and overrun_clr in the same cycle: the set wins.
  - A new press of the channel currently presented sets pending and is not an overrun.
- enable=0: pending cleared and presses not captured. An event already presented stays until acked. key_level keeps tracking.
- Mid-operation reset drops all pending and presented events with no partial output.

Optional Feature:
- Macro G15_KEY_T0_ALIGN_EN.
- When defined: adds input port T0 (1 bit, word-time strobe). IDLE->PRESENT happens only in cycles with T0=1, so events align to drum word boundaries; pending accumulates meanwhile.
- When undefined: the T0 port is absent and transitions occur on the first cycle with pending nonzero.

Decomposition:
- Package g15_key_pkg holds:
  - key_state_e {KS_IDLE, KS_PRESENT}
  - localparam indices for the standard 13 function keys (KEY_IDX_CIR_S=0, KEY_IDX_A=1, ...)
  - a priority-encode function for the lowest set bit
- One sub-module: g15_key_debounce (single-channel sync + counter + level + press). Instantiate it NUM_KEYS times with a generate loop.

Test Plan (NUM_KEYS=13, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, enable=1):
- key_raw[5] 0->1 held 20 cycles -> key_level[5] rises exactly 6 cycles later; key_press[5] is a 1-cycle pulse that cycle; key_valid=1 one cycle after the next IDLE cycle with key_code=5; ack clears it next cycle.
- key_raw[3] high for 3 synchronised cycles, then low -> key_level, key_press and key_valid stay 0 throughout.
- key_raw[9] and key_raw[2] rise in the same cycle -> code 2 presented first; after ack, code 9 two cycles later; no overrun.
- Hold key_ack=0 while presenting code 4; press key 7 twice (release/re-press, debounced) -> second press sets key_overrun=1. On ack, code 7 appears once. overrun_clr=1 returns key_overrun to 0.
- enable=0, then press key 1 -> key_press[1] pulses, key_valid stays 0; re-enable -> nothing appears.
- rst_n low for 1 cycle while key_valid=1 with code 6 and pending[8]=1 -> all outputs 0 immediately; no event after release until a new press.

Source files
------------

// File: rtl/g15_key_pkg.sv
// g15_key_pkg
// Shared types and helpers for the G-15 key synchroniser slice.
//   key_state_e  : presenter FSM states (idle / presenting an event)
//   KEY_IDX_*    : channel indices of the 13 standard typewriter function keys
//   lowest_set() : priority encoder returning the lowest set bit of a 32-bit vector
package g15_key_pkg;

  typedef enum logic {
    KS_IDLE    = 1'b0,
    KS_PRESENT = 1'b1
  } key_state_e;

  localparam int KEY_NUM_STD   = 13;
  localparam int KEY_IDX_CIR_S = 0;
  localparam int KEY_IDX_A     = 1;
  localparam int KEY_IDX_B     = 2;
  localparam int KEY_IDX_C     = 3;
  localparam int KEY_IDX_E     = 4;
  localparam int KEY_IDX_F     = 5;
  localparam int KEY_IDX_I     = 6;
  localparam int KEY_IDX_M     = 7;
  localparam int KEY_IDX_P     = 8;
  localparam int KEY_IDX_Q     = 9;
  localparam int KEY_IDX_R     = 10;
  localparam int KEY_IDX_S     = 11;
  localparam int KEY_IDX_T     = 12;

  // Scanning from the top down lets the lowest set bit overwrite any higher
  // one, so the result is the lowest index. An all-zero vector returns 0.
  function automatic logic [4:0] lowest_set(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/g15_key_debounce.sv
// g15_key_debounce
// Single key channel: multi-flop synchroniser, stability counter, debounced
// level and a one-cycle press pulse on the debounced 0->1 edge.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   raw_i   : raw asynchronous contact input (1 = closed)
//   level_o : debounced contact state
//   press_o : registered pulse, coincident with the level_o rise
module g15_key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   synced;
  logic                   differ;
  logic                   expire;

  assign synced = sync_q[SYNC_STAGES-1];
  assign differ = synced ^ level_q;
  assign expire = differ && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  // The counter only survives while the synchronised input disagrees with the
  // accepted level; any agreeing cycle restarts the stability window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (differ) begin
      if (expire) begin
        level_d = synced;
        press_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/g15_key_sync.sv
// g15_key_sync
// N-channel synchroniser/debouncer for typewriter function keys and switch
// contacts, with a one-at-a-time valid/ack press stream and overrun flag.
// Optional feature macro: G15_KEY_T0_ALIGN_EN adds input T0; events then
// leave idle only on T0 cycles so they align to drum word boundaries.
// Ports:
//   CLOCK       : system clock
//   rst_n       : asynchronous active-low reset
//   key_raw     : raw contact inputs, 1 = closed
//   enable      : ENABLE switch, 0 suppresses press capture
//   key_level   : debounced contact state
//   key_press   : one-cycle pulse on debounced 0->1
//   key_valid   : a press event is presented
//   key_code    : channel index of the presented event
//   key_ack     : consumer accepts the presented event
//   key_overrun : sticky, a press was lost
//   overrun_clr : clears key_overrun
//   T0          : word-time strobe (only with G15_KEY_T0_ALIGN_EN)
module g15_key_sync
  import g15_key_pkg::*;
#(
  parameter int NUM_KEYS        = 13,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CODE_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                CLOCK,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                enable,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                key_valid,
  output logic [CODE_W-1:0]   key_code,
  input  logic                key_ack,
  output logic                key_overrun,
  input  logic                overrun_clr
`ifdef G15_KEY_T0_ALIGN_EN
  ,
  input  logic                T0
`endif
);

  key_state_e          state_q, state_d;
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [NUM_KEYS-1:0] pendEff;
  logic [NUM_KEYS-1:0] setVec;
  logic [NUM_KEYS-1:0] consumeVec;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                overrun_q, overrun_d;
  logic                loadEvt;
  logic                t0Ok;
  logic [4:0]          lowIdx;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    g15_key_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (CLOCK),
      .rst_ni (rst_n),
      .raw_i  (key_raw[i]),
      .level_o(key_level[i]),
      .press_o(key_press[i])
    );
  end

`ifdef G15_KEY_T0_ALIGN_EN
  assign t0Ok = T0;
`else
  assign t0Ok = 1'b1;
`endif

  // Pending bits are about to be wiped while enable is low, so they are
  // hidden from the presenter in that window rather than half-delivered.
  assign pendEff    = enable ? pending_q : '0;
  assign lowIdx     = lowest_set(32'(pendEff));
  assign consumeVec = loadEvt ? (NUM_KEYS'(1) << lowIdx) : '0;

  // Presenter: idle picks the lowest pending channel, present holds it
  // until acknowledged.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    loadEvt = 1'b0;
    case (state_q)
      KS_IDLE: begin
        if ((|pendEff) && t0Ok) begin
          loadEvt = 1'b1;
          code_d  = CODE_W'(lowIdx);
          state_d = KS_PRESENT;
        end
      end
      KS_PRESENT: begin
        if (key_ack) state_d = KS_IDLE;
      end
      default: state_d = KS_IDLE;
    endcase
  end

  // A press on a channel that is being consumed in the same cycle re-arms
  // it cleanly; only a press landing on a still-waiting bit is lost.
  always_comb begin
    setVec    = key_press & {NUM_KEYS{enable}};
    pending_d = '0;
    if (enable) pending_d = (pending_q & ~consumeVec) | setVec;
    overrun_d = (|(setVec & pending_q & ~consumeVec)) |
                (overrun_q & ~overrun_clr);
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= KS_IDLE;
      pending_q <= '0;
      code_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      overrun_q <= overrun_d;
    end
  end

  assign key_valid   = (state_q == KS_PRESENT);
  assign key_code    = code_q;
  assign key_overrun = overrun_q;

endmodule

// File: tb/tb_g15_key_sync.sv
// tb_g15_key_sync
// Self-checking bench for g15_key_sync (13 keys, 2 sync stages, 4 debounce).
// Expected press events are queued when stimulus is driven and popped when
// the DUT presents them.
module tb_g15_key_sync;

  localparam int NK = 13;
  localparam int CW = 4;

  logic          CLOCK = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_raw;
  logic          enable;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic          key_valid;
  logic [CW-1:0] key_code;
  logic          key_ack;
  logic          key_overrun;
  logic          overrun_clr;
`ifdef G15_KEY_T0_ALIGN_EN
  logic          T0 = 1'b1;
`endif

  int checks   = 0;
  int failures = 0;
  int expQ[$];

  typedef struct {
    int key;
    int hold;
    bit accept;
  } vec_t;

  vec_t vecs[4];

  g15_key_sync #(
    .NUM_KEYS       (NK),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK      (CLOCK),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .enable     (enable),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ack    (key_ack),
    .key_overrun(key_overrun),
    .overrun_clr(overrun_clr)
`ifdef G15_KEY_T0_ALIGN_EN
    ,
    .T0         (T0)
`endif
  );

  // Free-running 10 ns clock.
  always #5 CLOCK = ~CLOCK;

  // Hard stop in case something upstream never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int key, input bit level, input bit expectEvent);
    key_raw[key] = level;
    if (expectEvent) expQ.push_back(key);
  endtask

  task automatic waitValid(input int maxTicks, output bit ok);
    int waited;
    waited = 0;
    ok = key_valid;
    while (!ok && waited < maxTicks) begin
      tick();
      waited++;
      ok = key_valid;
    end
  endtask

  task automatic serviceOne(input string name);
    bit ok;
    int expCode;
    waitValid(40, ok);
    checkOutput({name, " valid"}, int'(ok), 1);
    if (ok) begin
      if (expQ.size() == 0) begin
        checkOutput({name, " unexpected event code"}, int'(key_code), -1);
      end else begin
        expCode = expQ.pop_front();
        checkOutput({name, " code"}, int'(key_code), expCode);
      end
      key_ack = 1'b1;
      tick();
      key_ack = 1'b0;
      checkOutput({name, " valid after ack"}, int'(key_valid), 0);
    end
  endtask

  task automatic expectQuiet(input string name, input int n);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < n; t++) begin
      tick();
      if (key_valid) seen = 1'b1;
    end
    checkOutput(name, int'(seen), 0);
  endtask

  task automatic runTicks(input int n);
    for (int t = 0; t < n; t++) tick();
  endtask

  initial begin
    bit ok;
    int presses;
    bit validSeen;

    vecs[0] = '{5, 20, 1'b1};
    vecs[1] = '{3, 3, 1'b0};
    vecs[2] = '{0, 20, 1'b1};
    vecs[3] = '{12, 20, 1'b1};

    rst_n       = 1'b0;
    key_raw     = '0;
    enable      = 1'b1;
    key_ack     = 1'b0;
    overrun_clr = 1'b0;
    runTicks(3);
    checkOutput("reset key_level", int'(key_level), 0);
    checkOutput("reset key_press", int'(key_press), 0);
    checkOutput("reset key_valid", int'(key_valid), 0);
    checkOutput("reset key_code", int'(key_code), 0);
    checkOutput("reset key_overrun", int'(key_overrun), 0);
    rst_n = 1'b1;
    runTicks(2);

    // Single-key table: latency, press pulse, glitch rejection, delivery.
    for (int v = 0; v < 4; v++) begin
      int rise;
      int cnt;
      bit pressAtRise;
      string nm;
      rise = -1;
      cnt = 0;
      pressAtRise = 1'b0;
      nm = $sformatf("vec%0d key%0d", v, vecs[v].key);
      applyStimulus(vecs[v].key, 1'b1, vecs[v].accept);
      for (int t = 1; t <= vecs[v].hold; t++) begin
        tick();
        if (key_press[vecs[v].key]) cnt++;
        if (rise < 0 && key_level[vecs[v].key]) begin
          rise = t;
          pressAtRise = key_press[vecs[v].key];
        end
      end
      applyStimulus(vecs[v].key, 1'b0, 1'b0);
      for (int t = 0; t < 12; t++) begin
        tick();
        if (key_press[vecs[v].key]) cnt++;
      end
      checkOutput({nm, " level latency"}, rise, vecs[v].accept ? 6 : -1);
      checkOutput({nm, " press count"}, cnt, vecs[v].accept ? 1 : 0);
      checkOutput({nm, " press at rise"}, int'(pressAtRise), vecs[v].accept ? 1 : 0);
      checkOutput({nm, " level after release"}, int'(key_level[vecs[v].key]), 0);
      if (vecs[v].accept) serviceOne(nm);
      else expectQuiet({nm, " no event"}, 10);
    end

    // Simultaneous presses: lowest index first, next one two cycles after ack.
    applyStimulus(2, 1'b1, 1'b1);
    applyStimulus(9, 1'b1, 1'b1);
    runTicks(20);
    applyStimulus(2, 1'b0, 1'b0);
    applyStimulus(9, 1'b0, 1'b0);
    runTicks(10);
    serviceOne("pair first");
    tick();
    checkOutput("pair second after 2 cycles", int'(key_valid), 1);
    serviceOne("pair second");
    checkOutput("pair overrun", int'(key_overrun), 0);
    expectQuiet("pair drained", 8);

    // Overrun: repeated press of a key while another event is held unacked.
    applyStimulus(4, 1'b1, 1'b1);
    runTicks(20);
    applyStimulus(4, 1'b0, 1'b0);
    runTicks(12);
    waitValid(20, ok);
    checkOutput("ovr presenting valid", int'(ok), 1);
    checkOutput("ovr presenting code", int'(key_code), expQ[0]);
    applyStimulus(7, 1'b1, 1'b1);
    runTicks(12);
    applyStimulus(7, 1'b0, 1'b0);
    runTicks(12);
    checkOutput("ovr after first press", int'(key_overrun), 0);
    applyStimulus(7, 1'b1, 1'b0);
    runTicks(12);
    applyStimulus(7, 1'b0, 1'b0);
    runTicks(12);
    checkOutput("ovr after second press", int'(key_overrun), 1);
    checkOutput("ovr code held", int'(key_code), 4);
    serviceOne("ovr key4");
    serviceOne("ovr key7");
    expectQuiet("ovr key7 only once", 12);
    checkOutput("ovr sticky", int'(key_overrun), 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    checkOutput("ovr cleared", int'(key_overrun), 0);

    // Enable low: press still pulses but is never captured.
    enable = 1'b0;
    runTicks(2);
    presses = 0;
    validSeen = 1'b0;
    applyStimulus(1, 1'b1, 1'b0);
    for (int t = 0; t < 32; t++) begin
      if (t == 20) applyStimulus(1, 1'b0, 1'b0);
      tick();
      if (key_press[1]) presses++;
      if (key_valid) validSeen = 1'b1;
    end
    checkOutput("disabled press pulses", presses, 1);
    checkOutput("disabled no valid", int'(validSeen), 0);
    enable = 1'b1;
    expectQuiet("reenabled nothing", 15);

    // Mid-operation reset with one presented and one pending event.
    applyStimulus(6, 1'b1, 1'b1);
    runTicks(20);
    applyStimulus(6, 1'b0, 1'b0);
    runTicks(12);
    waitValid(20, ok);
    checkOutput("rst presenting code", int'(key_code), expQ[0]);
    applyStimulus(8, 1'b1, 1'b0);
    presses = 0;
    for (int t = 0; t < 15 && presses == 0; t++) begin
      tick();
      if (key_press[8]) presses++;
    end
    checkOutput("rst key8 pressed", presses, 1);
    runTicks(2);
    checkOutput("rst still presenting", int'(key_valid), 1);
    key_raw = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst async valid", int'(key_valid), 0);
    checkOutput("rst async code", int'(key_code), 0);
    checkOutput("rst async level", int'(key_level), 0);
    checkOutput("rst async overrun", int'(key_overrun), 0);
    @(posedge CLOCK);
    #1;
    rst_n = 1'b1;
    expQ.delete();
    expectQuiet("rst no stale event", 20);
    applyStimulus(11, 1'b1, 1'b1);
    runTicks(20);
    applyStimulus(11, 1'b0, 1'b0);
    runTicks(12);
    serviceOne("rst new press");
    checkOutput("scoreboard empty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
